// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage issue front end for the HI/LO multiply/divide unit.
// Turns decoded EX instructions into one-cycle one-hot op pulses for
// mult_div. It also tracks the single outstanding HI/LO write, stalls
// dependent MFHI/MFLO or MD ops, and returns HI/LO read data to EX.
//
// Optional build macro: MD_MT_FWD_EN. When defined, an MTHI/MTLO value is held
// in a shadow register. A matching MFHI/MFLO in the MT wait window is then
// served from the shadow register instead of stalling.
//
// Handshake: ex_valid/ex_allowout form a valid/ready pair. An MD op transfers
// to mult_div only in a cycle with ex_valid, ex_allowout, no flush and an idle
// unit. That transfer is marked by the md_op pulse. ex_md_stall tells EX to hold
// its instruction. EX must keep ex_valid and the decode stable while stalled.
module md_issue_ctrl #(
   parameter int DW        = 32,
   parameter int MUL_LAT   = 2,
   parameter int MT_LAT    = 1,
   parameter int DIV_GUARD = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ex_valid,
   input  logic [2:0]    ex_md_type,
   input  logic          ex_mfhi,
   input  logic          ex_mflo,
   input  logic [DW-1:0] ex_src0,
   input  logic [DW-1:0] ex_src1,
   input  logic          ex_allowout,
   input  logic          flush,
   input  logic          md_accessible,
   input  logic [DW-1:0] md_res,
   output logic [5:0]    md_op,
   output logic [DW-1:0] md_in0,
   output logic [DW-1:0] md_in1,
   output logic          md_read_request,
   output logic          ex_md_stall,
   output logic [DW-1:0] ex_md_rdata,
   output logic          md_busy
);

   // Decoded EX op types; 0 and 7 mean "no MD op".
   localparam logic [2:0] TY_MULT  = 3'd1;
   localparam logic [2:0] TY_MULTU = 3'd2;
   localparam logic [2:0] TY_DIV   = 3'd3;
   localparam logic [2:0] TY_DIVU  = 3'd4;
   localparam logic [2:0] TY_MTHI  = 3'd5;
   localparam logic [2:0] TY_MTLO  = 3'd6;

   // Wait-counter load values; the counter is 3 bits and never wraps.
   localparam logic [2:0] MUL_LAT_C   = 3'(MUL_LAT);
   localparam logic [2:0] MT_LAT_C    = 3'(MT_LAT);
   localparam logic [2:0] DIV_GUARD_C = 3'(DIV_GUARD);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_MT_WAIT  = 2'd2,
      ST_DIV_WAIT = 2'd3
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [2:0]    cnt_q;
   logic [2:0]    cnt_d;

   logic          is_mul;
   logic          is_div;
   logic          is_mt;
   logic          op_valid;
   logic [5:0]    op_onehot;
   logic          in_idle;
   logic          issue;
   logic          mf_req;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;

   // Decode the EX op type into an op class and its one-hot pulse pattern.
   always_comb begin
      is_mul    = 1'b0;
      is_div    = 1'b0;
      is_mt     = 1'b0;
      op_onehot = 6'b000000;
      case (ex_md_type)
         TY_MULT:  begin is_mul = 1'b1; op_onehot = 6'b000001; end
         TY_MULTU: begin is_mul = 1'b1; op_onehot = 6'b000010; end
         TY_DIV:   begin is_div = 1'b1; op_onehot = 6'b000100; end
         TY_DIVU:  begin is_div = 1'b1; op_onehot = 6'b001000; end
         TY_MTHI:  begin is_mt  = 1'b1; op_onehot = 6'b010000; end
         TY_MTLO:  begin is_mt  = 1'b1; op_onehot = 6'b100000; end
         default:  begin op_onehot = 6'b000000; end
      endcase
      op_valid = is_mul | is_div | is_mt;
   end

   assign in_idle = (state_q == ST_IDLE);
   assign mf_req  = ex_mfhi | ex_mflo;

   // Only one HI/LO write may be outstanding, so issue requires an idle unit.
   // A flush in the same cycle wins over the issue.
   assign issue = ex_valid & op_valid & in_idle & ex_allowout & ~flush;

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The mult and MT waits are fixed length. The divide
   // waits out a guard interval before md_accessible is trusted, then waits
   // for that flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               if (is_mul) begin
                  state_d = ST_MUL_WAIT;
                  cnt_d   = MUL_LAT_C;
               end else if (is_mt) begin
                  state_d = ST_MT_WAIT;
                  cnt_d   = MT_LAT_C;
               end else begin
                  state_d = ST_DIV_WAIT;
                  cnt_d   = DIV_GUARD_C;
               end
            end
         end
         ST_MUL_WAIT, ST_MT_WAIT: begin
            // A count of 0 is unreachable here. Treating it like 1 guarantees
            // the counter can never wrap.
            if (cnt_q <= 3'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_DIV_WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else if (md_accessible) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
      // mult_div drops the pending write itself, so a flush only has to
      // release the scoreboard.
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = 3'd0;
      end
   end

`ifdef MD_MT_FWD_EN
   logic [DW-1:0] shadow_q;
   logic [1:0]    tag_q;   // [1] HI, [0] LO

   // Capture the MTHI/MTLO operand and which register it targets.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         shadow_q <= '0;
         tag_q    <= 2'b00;
      end else if (issue) begin
         tag_q <= {ex_md_type == TY_MTHI, ex_md_type == TY_MTLO};
         if (is_mt) begin
            shadow_q <= md_in0;
         end
      end
   end

   // An MFHI/MFLO hits when it reads the register being written. If both
   // read bits are set, HI is the selected register.
   assign fwd_hit  = (state_q == ST_MT_WAIT) &
                     (ex_mfhi ? tag_q[1] : (ex_mflo & tag_q[0]));
   assign fwd_data = shadow_q;
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   // Outputs toward mult_div.
   assign md_op           = issue ? op_onehot : 6'b000000;
   assign md_in0          = ex_src0;
   assign md_in1          = ex_src1;
   assign md_read_request = ex_mfhi;

   // Outputs toward EX.
   assign md_busy     = ~in_idle;
   assign ex_md_stall = ex_valid & ~flush & ~in_idle & (mf_req | op_valid) & ~fwd_hit;
   assign ex_md_rdata = in_idle ? md_res : (fwd_hit ? fwd_data : '0);

   // At most one op pulse per cycle, and no pulse unless the unit was idle.
   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(md_op));
   assert property (@(posedge clk) disable iff (!rst_n) (md_op != 6'b0) |-> in_idle);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed bench for md_issue_ctrl with a cycle-level model.
// Build macro MD_MT_FWD_EN selects the forwarding expectations.
module tb_md_issue_ctrl;

   localparam int DW        = 32;
   localparam int MUL_LAT   = 2;
   localparam int MT_LAT    = 1;
   localparam int DIV_GUARD = 2;
`ifdef MD_MT_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_valid;
   logic [2:0]    ex_md_type;
   logic          ex_mfhi;
   logic          ex_mflo;
   logic [DW-1:0] ex_src0;
   logic [DW-1:0] ex_src1;
   logic          ex_allowout;
   logic          flush;
   logic          md_accessible;
   logic [DW-1:0] md_res;
   logic [5:0]    md_op;
   logic [DW-1:0] md_in0;
   logic [DW-1:0] md_in1;
   logic          md_read_request;
   logic          ex_md_stall;
   logic [DW-1:0] ex_md_rdata;
   logic          md_busy;

   always #5 clk = ~clk;

   md_issue_ctrl #(
      .DW(DW), .MUL_LAT(MUL_LAT), .MT_LAT(MT_LAT), .DIV_GUARD(DIV_GUARD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_md_type(ex_md_type),
      .ex_mfhi(ex_mfhi), .ex_mflo(ex_mflo), .ex_src0(ex_src0), .ex_src1(ex_src1),
      .ex_allowout(ex_allowout), .flush(flush), .md_accessible(md_accessible),
      .md_res(md_res), .md_op(md_op), .md_in0(md_in0), .md_in1(md_in1),
      .md_read_request(md_read_request), .ex_md_stall(ex_md_stall),
      .ex_md_rdata(ex_md_rdata), .md_busy(md_busy)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];   // expected md_op pulses, in issue order

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The model keeps the issue cycle of the last accepted op. Busy windows
   // are computed from cycle distances: a mult stays pending for MUL_LAT
   // cycles and an MT for MT_LAT cycles. A divide stays pending until the
   // first md_accessible seen more than DIV_GUARD cycles after issue.
   bit            m_valid    = 1'b0;
   bit            m_active   = 1'b0;
   bit            m_div_done = 1'b0;
   int            m_kind     = 0;   // 1 mult, 2 mt, 3 div
   int            m_issue_cyc = 0;
   int            cyc        = 0;
   logic [DW-1:0] m_shadow   = '0;
   bit            m_tag_hi   = 1'b0;

   // Compare process: evaluate the model on the falling edge, compare, advance.
   always @(negedge clk) begin
      bit            busy;
      bit            tv;
      bit            issue;
      bit            mf;
      bit            hit;
      bit            stall_e;
      logic [5:0]    op_e;
      logic [DW-1:0] rdata_e;
      busy = 1'b0;
      if (m_active) begin
         case (m_kind)
            1:       busy = (cyc - m_issue_cyc) <= MUL_LAT;
            2:       busy = (cyc - m_issue_cyc) <= MT_LAT;
            default: busy = !m_div_done;
         endcase
      end
      tv      = (ex_md_type >= 3'd1) && (ex_md_type <= 3'd6);
      issue   = ex_valid && tv && !busy && ex_allowout && !flush;
      op_e    = issue ? (6'b000001 << (ex_md_type - 3'd1)) : 6'b000000;
      mf      = ex_mfhi || ex_mflo;
      hit     = FWD_EN && busy && (m_kind == 2) && mf && (ex_mfhi ? m_tag_hi : !m_tag_hi);
      stall_e = ex_valid && !flush && busy && (mf || tv) && !hit;
      rdata_e = !busy ? md_res : (hit ? m_shadow : '0);

      if (m_valid) begin
         chk("m_md_op", md_op, op_e);
         chk("m_md_in0", md_in0, ex_src0);
         chk("m_md_in1", md_in1, ex_src1);
         chk("m_read_req", md_read_request, ex_mfhi);
         chk("m_stall", ex_md_stall, stall_e);
         chk("m_rdata", ex_md_rdata, rdata_e);
         chk("m_busy", md_busy, busy);
         if (md_op != 6'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pulse_unexpected: got %b, expected no pulse (t=%0t)", md_op, $time);
            end else begin
               chk("pulse_order", md_op, exp_q.pop_front());
            end
         end
      end

      if (!rst_n) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
      end else if (flush) begin
         m_active = 1'b0;
      end else if (issue) begin
         m_active    = 1'b1;
         m_issue_cyc = cyc;
         m_div_done  = 1'b0;
         m_kind      = (ex_md_type <= 3'd2) ? 1 : ((ex_md_type <= 3'd4) ? 3 : 2);
         if (m_kind == 2) begin
            m_shadow = ex_src0;
            m_tag_hi = (ex_md_type == 3'd5);
         end
      end else if (m_active && m_kind == 3 && !m_div_done &&
                   (cyc - m_issue_cyc) > DIV_GUARD && md_accessible) begin
         m_div_done = 1'b1;
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   int drv_cyc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      md_res = 32'hA5A5_0000 + drv_cyc;
      drv_cyc++;
   endtask

   task automatic idle_inputs();
      ex_valid    = 1'b0;
      ex_md_type  = 3'd0;
      ex_mfhi     = 1'b0;
      ex_mflo     = 1'b0;
      ex_src0     = '0;
      ex_src1     = '0;
      flush       = 1'b0;
      ex_allowout = 1'b1;
   endtask

   task automatic send(input logic [2:0] ty, input logic [DW-1:0] a, input logic [DW-1:0] b);
      ex_valid   = 1'b1;
      ex_md_type = ty;
      ex_mfhi    = 1'b0;
      ex_mflo    = 1'b0;
      ex_src0    = a;
      ex_src1    = b;
   endtask

   task automatic read_hilo(input logic hi, input logic lo);
      ex_valid   = 1'b1;
      ex_md_type = 3'd0;
      ex_mfhi    = hi;
      ex_mflo    = lo;
      ex_src0    = '0;
      ex_src1    = '0;
   endtask

   // Hold whatever is in EX and count stalled cycles until it is released.
   task automatic count_stalls(output int n, input int budget);
      n = 0;
      repeat (budget) begin
         #1;
         if (!ex_md_stall) break;
         n++;
         tick();
      end
   endtask

   // Bounded wait for the unit to go idle.
   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (md_busy === 1'b1 && n < 60) begin
         tick();
         n++;
      end
      #1;
      chk(name, md_busy, 1'b0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int stalls;
      int k;
      idle_inputs();
      md_accessible = 1'b1;
      md_res        = '0;
      rst_n         = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      chk("reset_busy", md_busy, 1'b0);
      chk("reset_stall", ex_md_stall, 1'b0);
      chk("reset_op", md_op, 6'b0);
      chk("reset_rreq", md_read_request, 1'b0);
      tick();

      // Mult then MFLO: MFLO is held for the two mult cycles.
      send(3'd1, 32'h0000_0003, 32'hFFFF_FFFF);
      exp_q.push_back(6'b000001);
      #1;
      chk("mult_op", md_op, 6'b000001);
      chk("mult_in0", md_in0, 32'h0000_0003);
      chk("mult_in1", md_in1, 32'hFFFF_FFFF);
      chk("mult_no_self_stall", ex_md_stall, 1'b0);
      tick();
      read_hilo(1'b0, 1'b1);
      count_stalls(stalls, 20);
      chk("mflo_stall_cycles", stalls, 2);
      chk("mflo_rdata", ex_md_rdata, md_res);
      chk("mflo_rreq", md_read_request, 1'b0);
      chk("mult_busy_fell", md_busy, 1'b0);
      tick();
      idle_inputs();
      tick();

      // Divu with md_accessible low for 35 cycles; MFHI waits for the flag.
      send(3'd4, 32'd100, 32'd7);
      md_accessible = 1'b0;
      exp_q.push_back(6'b001000);
      #1;
      chk("divu_op", md_op, 6'b001000);
      tick();
      read_hilo(1'b1, 1'b0);
      k      = 0;
      stalls = 0;
      repeat (80) begin
         md_accessible = (k >= 35);
         #1;
         if (!ex_md_stall) break;
         stalls++;
         k++;
         tick();
      end
      chk("mfhi_div_stall_cycles", stalls, 36);
      chk("mfhi_div_rdata", ex_md_rdata, md_res);
      chk("mfhi_div_rreq", md_read_request, 1'b1);
      tick();
      idle_inputs();
      md_accessible = 1'b1;
      tick();

      // Back-to-back multu then div: div waits two cycles and issues once.
      send(3'd2, 32'd5, 32'd6);
      exp_q.push_back(6'b000010);
      #1;
      chk("multu_op", md_op, 6'b000010);
      tick();
      send(3'd3, 32'd40, 32'd8);
      exp_q.push_back(6'b000100);
      count_stalls(stalls, 20);
      chk("div_b2b_stall_cycles", stalls, 2);
      chk("div_b2b_op", md_op, 6'b000100);
      tick();
      idle_inputs();
      wait_idle("div_b2b_done");
      tick();

      // Flush in the 5th DIV_WAIT cycle, then an immediate mult.
      send(3'd3, 32'd9, 32'd3);
      md_accessible = 1'b0;
      exp_q.push_back(6'b000100);
      #1;
      chk("div_fl_op", md_op, 6'b000100);
      tick();
      read_hilo(1'b1, 1'b0);
      repeat (4) tick();
      flush = 1'b1;
      #1;
      chk("flush_cycle_stall", ex_md_stall, 1'b0);
      chk("flush_cycle_busy", md_busy, 1'b1);
      tick();
      flush = 1'b0;
      send(3'd1, 32'd2, 32'd3);
      exp_q.push_back(6'b000001);
      #1;
      chk("after_flush_busy", md_busy, 1'b0);
      chk("after_flush_stall", ex_md_stall, 1'b0);
      chk("after_flush_mult_op", md_op, 6'b000001);
      tick();
      idle_inputs();
      md_accessible = 1'b1;
      wait_idle("after_flush_mult_done");
      tick();

      // Flush together with an mthi: no pulse, unit stays idle.
      send(3'd5, 32'h1111_1111, 32'd0);
      flush = 1'b1;
      #1;
      chk("flush_issue_op", md_op, 6'b0);
      tick();
      idle_inputs();
      #1;
      chk("flush_issue_busy", md_busy, 1'b0);
      tick();

      // MTHI then MFHI.
      send(3'd5, 32'hDEAD_BEEF, 32'd0);
      exp_q.push_back(6'b010000);
      #1;
      chk("mthi_op", md_op, 6'b010000);
      chk("mthi_in0", md_in0, 32'hDEAD_BEEF);
      tick();
      read_hilo(1'b1, 1'b0);
      #1;
`ifdef MD_MT_FWD_EN
      chk("fwd_mfhi_stall", ex_md_stall, 1'b0);
      chk("fwd_mfhi_rdata", ex_md_rdata, 32'hDEAD_BEEF);
`else
      chk("mfhi_after_mthi_stall", ex_md_stall, 1'b1);
      chk("mfhi_after_mthi_rdata0", ex_md_rdata, 32'h0);
      tick();
      #1;
      chk("mfhi_after_mthi_release", ex_md_stall, 1'b0);
      chk("mfhi_after_mthi_rdata", ex_md_rdata, md_res);
`endif
      tick();
      idle_inputs();
      tick();

      // MTLO then MFHI: the read targets the other register and always stalls.
      send(3'd6, 32'h0BAD_F00D, 32'd0);
      exp_q.push_back(6'b100000);
      tick();
      read_hilo(1'b1, 1'b0);
      #1;
      chk("mismatch_read_stall", ex_md_stall, 1'b1);
      tick();
      #1;
      chk("mismatch_read_release", ex_md_stall, 1'b0);
      tick();
      idle_inputs();
      tick();

      // MTLO then MFLO.
      send(3'd6, 32'h0BAD_F00D, 32'd0);
      exp_q.push_back(6'b100000);
      tick();
      read_hilo(1'b0, 1'b1);
      #1;
`ifdef MD_MT_FWD_EN
      chk("fwd_mflo_rdata", ex_md_rdata, 32'h0BAD_F00D);
`else
      chk("mflo_after_mtlo_stall", ex_md_stall, 1'b1);
`endif
      tick();
      idle_inputs();
      tick();

      // MTHI then an illegal MFHI+MFLO: HI is selected.
      send(3'd5, 32'hCAFE_0001, 32'd0);
      exp_q.push_back(6'b010000);
      tick();
      read_hilo(1'b1, 1'b1);
      #1;
      chk("both_read_rreq", md_read_request, 1'b1);
`ifdef MD_MT_FWD_EN
      chk("both_read_fwd_rdata", ex_md_rdata, 32'hCAFE_0001);
`else
      chk("both_read_stall", ex_md_stall, 1'b1);
`endif
      tick();
      idle_inputs();
      tick();

      // Type 7 is not an op; a mult without ex_allowout is not accepted.
      send(3'd7, 32'd1, 32'd2);
      #1;
      chk("type7_op", md_op, 6'b0);
      tick();
      send(3'd1, 32'd1, 32'd2);
      ex_allowout = 1'b0;
      #1;
      chk("no_allowout_op", md_op, 6'b0);
      tick();
      idle_inputs();
      #1;
      chk("no_allowout_busy", md_busy, 1'b0);
      tick();

      // Reset in the middle of DIV_WAIT.
      send(3'd3, 32'd77, 32'd11);
      md_accessible = 1'b0;
      exp_q.push_back(6'b000100);
      tick();
      read_hilo(1'b1, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("pre_reset_stall", ex_md_stall, 1'b1);
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_reset_stall", ex_md_stall, 1'b0);
      chk("post_reset_busy", md_busy, 1'b0);
      tick();
      idle_inputs();
      md_accessible = 1'b1;
      repeat (3) tick();

      #1;
      chk("pulse_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
